// File: rtl/activation_out_writer.sv
// activation_out_writer
//   Return path of the activation buffer. Collects per-lane PE results into a
//   staging vector and writes each complete LANES x DW vector as one row of an
//   internal ROWS-deep buffer. The host reads the buffer over a 32-bit
//   BRAM-style port with a fixed two-stage pipeline.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : one-cycle pulse, begins a capture job
//   addr_start, last_row  : first row written, job writes last_row+1 rows
//   activation_out        : lane data, lane i at [DW*i +: DW]
//   activation_out_valid  : per-lane valid
//   busy, done, overflow  : job status; overflow is sticky until start/reset
//   s_ena, s_addra        : host read enable / byte address
//   s_douta               : host read data
module activation_out_writer #(
  parameter int unsigned LANES  = 32,
  parameter int unsigned DW     = 16,
  parameter int unsigned ROWS   = 2048,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(ROWS)-1:0]         addr_start,
  input  logic [4:0]                      last_row,
  input  logic [LANES*DW-1:0]             activation_out,
  input  logic [LANES-1:0]                activation_out_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  input  logic                            s_ena,
  input  logic [$clog2(ROWS)+$clog2(LANES*DW/8)-1:0] s_addra,
  output logic [31:0]                     s_douta
);

  localparam int unsigned AW = $clog2(ROWS);
  localparam int unsigned RW = LANES * DW;
  localparam int unsigned BW = $clog2(RW / 8);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] pending_q, pending_d;
  logic [AW-1:0]    wr_row_q, wr_row_d;
  logic [4:0]       rows_left_q, rows_left_d;
  logic             overflow_d;
  logic [LANES-1:0] lane_load;
  logic             ram_we;
  logic [RW-1:0]    staging_q;

  logic [RW-1:0]    mem [ROWS];
  logic [RW-1:0]    ram_q;
  logic [BW-3:0]    word_q;
  logic [RD_LAT-2:0] ena_sr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^s_addra[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      wr_row_q    <= '0;
      rows_left_q <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      wr_row_q    <= wr_row_d;
      rows_left_q <= rows_left_d;
      overflow    <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    wr_row_d    = wr_row_q;
    rows_left_d = rows_left_q;
    overflow_d  = overflow;
    lane_load   = '0;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_row_d    = addr_start;
          rows_left_d = last_row;
          overflow_d  = 1'b0;
          pending_d   = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        // Only lanes not yet staged load; a repeat valid keeps the first value.
        lane_load = activation_out_valid & ~pending_q;
        pending_d = pending_q | activation_out_valid;
        if (|(activation_out_valid & pending_q)) overflow_d = 1'b1;
        if (&pending_d) state_d = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (rows_left_q == '0) begin
          pending_d = '0;
          state_d   = DONE;
        end else begin
          // Valids landing during the write seed the next row's mask.
          lane_load   = activation_out_valid;
          pending_d   = activation_out_valid;
          rows_left_d = rows_left_q - 5'd1;
          wr_row_d    = wr_row_q + 1'b1;
          state_d     = COLLECT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_load[i]) staging_q[i*DW +: DW] <= activation_out[i*DW +: DW];
    end
  end

  // Read and write share one edge, so a same-row read returns the old row.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_row_q] <= staging_q;
    if (s_ena) begin
      ram_q  <= mem[s_addra[AW+BW-1:BW]];
      word_q <= s_addra[BW-1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ena_sr  <= '0;
      s_douta <= '0;
    end else begin
      ena_sr[0] <= s_ena;
      for (int unsigned i = 1; i < RD_LAT - 1; i++) ena_sr[i] <= ena_sr[i-1];
      if (ena_sr[RD_LAT-2]) s_douta <= ram_q[{word_q, 5'b0} +: 32];
    end
  end

endmodule

// File: tb/tb_activation_out_writer.sv
module tb_activation_out_writer;

  logic          clk;
  logic          reset;
  logic          start;
  logic [10:0]   addr_start;
  logic [4:0]    last_row;
  logic [511:0]  activation_out;
  logic [31:0]   activation_out_valid;
  logic          busy, done, overflow;
  logic          s_ena;
  logic [16:0]   s_addra;
  logic [31:0]   s_douta;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]  exp_q [$];
  logic [511:0] model [int];

  activation_out_writer #(.LANES(32), .DW(16), .ROWS(2048), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_start(addr_start),
    .last_row(last_row), .activation_out(activation_out),
    .activation_out_valid(activation_out_valid), .busy(busy), .done(done),
    .overflow(overflow), .s_ena(s_ena), .s_addra(s_addra), .s_douta(s_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkvec(input int seed);
    logic [511:0] v;
    for (int i = 0; i < 32; i++) v[i*16 +: 16] = 16'(seed * 256 + i);
    return v;
  endfunction

  task automatic drive(input logic [511:0] v, input logic [31:0] m);
    activation_out       = v;
    activation_out_valid = m;
  endtask

  task automatic do_start(input int addr, input int last);
    start      = 1'b1;
    addr_start = 11'(addr);
    last_row   = 5'(last);
    tick();
    start = 1'b0;
  endtask

  // Issue a host read; expected word is queued now and compared when s_douta updates.
  task automatic rd_check(input string tag, input int row, input int word);
    logic [511:0] r;
    r       = model[row];
    s_ena   = 1'b1;
    s_addra = {11'(row), 4'(word), 2'b00};
    exp_q.push_back(r[word*32 +: 32]);
    tick();
    s_ena = 1'b0;
    tick();
    chk(tag, s_douta, exp_q.pop_front());
  endtask

  task automatic check_row(input string tag, input int row);
    rd_check(tag, row, 0);
    rd_check(tag, row, 7);
    rd_check(tag, row, 15);
  endtask

  initial begin
    logic [511:0] v, vb;
    reset = 1'b1; start = 1'b0; addr_start = '0; last_row = '0;
    activation_out = '0; activation_out_valid = '0; s_ena = 1'b0; s_addra = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_douta", s_douta, 0);
    reset = 1'b0;
    tick();

    // Single row at 5
    do_start(5, 0);
    chk("t1_busy", busy, 1);
    v = mkvec(1); model[5] = v;
    drive(v, '1); tick(); drive('0, '0);
    chk("t1_done_c1", done, 0);
    tick();
    chk("t1_done_c2", done, 1);
    tick();
    chk("t1_done_after", done, 0);
    chk("t1_busy_after", busy, 0);
    s_ena = 1'b1; s_addra = 17'h140; exp_q.push_back(32'h01010100);
    tick(); s_ena = 1'b0; tick();
    chk("t1_read_140", s_douta, exp_q.pop_front());
    tick();
    chk("t1_hold", s_douta, 32'h01010100);
    rd_check("t1_w15", 5, 15);

    // Valids while idle are ignored
    drive(mkvec(50), '1); tick(); drive('0, '0);
    chk("idle_busy", busy, 0);
    chk("idle_ovf", overflow, 0);

    // Staggered lanes
    do_start(20, 0);
    v = mkvec(2); model[20] = v;
    drive(v, 32'h0000FFFF); tick();
    drive(v, 32'h0); tick(); tick();
    chk("t2_busy_wait", busy, 1);
    chk("t2_done_wait", done, 0);
    drive(v, 32'hFFFF0000); tick();
    drive('0, '0); tick();
    chk("t2_done", done, 1);
    chk("t2_ovf", overflow, 0);
    tick();
    check_row("t2_row20", 20);

    // Overflow: lane 3 repeated before lane 31
    do_start(30, 0);
    v = mkvec(3); model[30] = v;
    drive(v, 32'h7FFFFFFF); tick();
    chk("t3_ovf_pre", overflow, 0);
    drive(mkvec(9), 32'h00000008); tick();
    chk("t3_ovf_set", overflow, 1);
    drive(v, 32'h80000000); tick();
    drive('0, '0); tick();
    chk("t3_done", done, 1);
    tick();
    chk("t3_ovf_sticky", overflow, 1);
    rd_check("t3_lane3", 30, 1);
    rd_check("t3_lane31", 30, 15);
    do_start(40, 0);
    chk("t3_ovf_clr", overflow, 0);
    v = mkvec(5); model[40] = v;
    drive(v, '1); tick(); drive('0, '0); tick(); tick();

    // Multi-row with wrap
    do_start(2046, 3);
    for (int k = 0; k < 4; k++) begin
      v = mkvec(4 + k + 20); model[(2046 + k) % 2048] = v;
      drive(v, '1); tick(); drive('0, '0);
      chk("t4_no_done_w", done, 0);
      if (k < 3) begin
        tick();
        chk("t4_no_done_c", done, 0);
      end
    end
    tick();
    chk("t4_done", done, 1);
    tick();
    chk("t4_done_end", done, 0);
    chk("t4_busy_end", busy, 0);
    check_row("t4_r2046", 2046);
    check_row("t4_r2047", 2047);
    check_row("t4_r0", 0);
    check_row("t4_r1", 1);

    // Read/write collision on row 7
    do_start(7, 0);
    v = mkvec(8); model[7] = v;
    drive(v, '1); tick(); drive('0, '0); tick(); tick();
    do_start(7, 0);
    v = mkvec(9);
    drive(v, '1); tick(); drive('0, '0);
    s_ena = 1'b1; s_addra = {11'd7, 4'd0, 2'b00};
    vb = model[7]; exp_q.push_back(vb[31:0]);
    tick(); s_ena = 1'b0; model[7] = v;
    tick();
    chk("t5_read_first", s_douta, exp_q.pop_front());
    check_row("t5_row7_new", 7);

    // Back-to-back vectors: second one arrives during WRITE
    do_start(9, 1);
    v = mkvec(10); vb = mkvec(11); model[9] = v; model[10] = vb;
    drive(v, '1); tick();
    drive(vb, '1); tick();
    drive('0, '0);
    chk("t6_ovf", overflow, 0);
    tick(); tick();
    chk("t6_done", done, 1);
    tick();
    check_row("t6_row9", 9);
    check_row("t6_row10", 10);

    // Known contents for rows 2,3
    do_start(2, 1);
    v = mkvec(30); vb = mkvec(31); model[2] = v; model[3] = vb;
    drive(v, '1); tick(); drive('0, '0); tick();
    drive(vb, '1); tick(); drive('0, '0); tick(); tick();

    // Reset mid-job after two rows
    do_start(0, 3);
    for (int k = 0; k < 2; k++) begin
      v = mkvec(12 + k); model[k] = v;
      drive(v, '1); tick(); drive('0, '0); tick();
    end
    drive(mkvec(14), '1);
    reset = 1'b1;
    #1;
    chk("t7_busy_rst", busy, 0);
    chk("t7_done_rst", done, 0);
    chk("t7_douta_rst", s_douta, 0);
    tick();
    reset = 1'b0;
    tick();
    drive(mkvec(15), '1); tick();
    drive('0, '0);
    for (int k = 0; k < 4; k++) begin
      chk("t7_no_done", done, 0);
      tick();
    end
    chk("t7_busy_after", busy, 0);
    check_row("t7_row0", 0);
    check_row("t7_row1", 1);
    check_row("t7_row2", 2);
    check_row("t7_row3", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
